scr1_simd_accel: RTL and testbench

//  DMEM-mapped SIMD lane accelerator on the SCR1 core data interface; next gen of the bytewise go/done multiplier.

---
 rtl/scr1_simd_accel_if.sv | 22 ++
 rtl/scr1_simd_accel.sv | 185 ++++++++++++++++++
 tb/tb_scr1_simd_accel.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_simd_accel_if.sv
// SCR1 data-memory port bundle used by the SIMD lane accelerator.
// Encodings: cmd 0 RD / 1 WR; width 00 BYTE, 01 HWORD, 10 WORD; resp 00 NOTRDY, 01 RDY_OK.
interface scr1_simd_accel_if;
  logic        dmem_req_ack;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/scr1_simd_accel.sv
// DMEM-mapped SIMD lane accelerator: A/B operand buffers, MUL/ADD/MAC over lanes into C and ACC,
// walked LANES_PER_CYC lanes per clock by a small IDLE/RUN/DONE controller.
module scr1_simd_accel #(
  parameter int LANE_W        = 8,
  parameter int LANES_PER_CYC = 1,
  parameter int NWORDS        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  scr1_simd_accel_if.slave dmem,
  output logic             irq
);
  localparam int LPW   = 32 / LANE_W;
  localparam int SPW   = LPW / LANES_PER_CYC;
  localparam int STEPS = NWORDS * SPW;
  localparam int SW    = $clog2(STEPS + 1);
  localparam int WW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PW    = 2 * LANE_W;

  localparam logic       CMD_WR      = 1'b1;
  localparam logic [1:0] WID_BYTE    = 2'b00;
  localparam logic [1:0] WID_HWORD   = 2'b01;
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] MODE_ADD    = 2'b01;
  localparam logic [1:0] MODE_MAC    = 2'b10;
  localparam logic [1:0] MODE_RSV    = 2'b11;
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_RUN      = 2'b01;
  localparam logic [1:0] ST_DONE     = 2'b10;

  logic [31:0]   a_mem [NWORDS];
  logic [31:0]   b_mem [NWORDS];
  logic [31:0]   c_mem [NWORDS];
  logic [1:0]    state, ctrl_mode, run_mode;
  logic          ctrl_ie;
  logic [SW-1:0] step;
  logic [15:0]   cycles;
  logic [31:0]   acc;
  logic [1:0]    resp_p1;
  logic [31:0]   rdata_p1;

  function automatic logic [PW-1:0] lane_mul(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  function automatic logic [LANE_W-1:0] lane_res(input logic [1:0] mode, input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    logic [PW-1:0] p;
    p = lane_mul(a, b);
    return (mode == MODE_ADD) ? LANE_W'(a + b) : p[LANE_W-1:0];
  endfunction

  logic [9:0]    addr;
  logic [1:0]    off, region, new_mode;
  logic [5:0]    idx;
  logic          idx_ok, busy, done, wr, ctrl_wr, go_req, start, done_w1c, a_wr, b_wr;
  logic [WW-1:0] wi;
  logic [3:0]    be;
  logic [31:0]   wd, bmask, rword, ctrl_rd;
  logic          unused_addr;

  assign addr        = dmem.dmem_addr[9:0];
  assign unused_addr = ^dmem.dmem_addr[31:10];
  assign off         = addr[1:0];
  assign region      = addr[9:8];
  assign idx         = addr[7:2];
  assign idx_ok      = int'(idx) < NWORDS;
  assign wi          = WW'(idx);
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign ctrl_rd     = {done, busy, 26'b0, ctrl_ie, ctrl_mode, 1'b0};

  always_comb begin
    case (dmem.dmem_width)
      WID_BYTE:  be = 4'b0001 << off;
      WID_HWORD: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
  end

  // Write data arrives right-aligned; move it onto the addressed byte lanes.
  assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wd    = dmem.dmem_wdata << {off, 3'b000};

  always_comb begin
    rword = '0;
    case (region)
      2'd0: begin
        case (idx)
          6'd0:    rword = ctrl_rd;
          6'd1:    rword = {16'b0, cycles};
          6'd2:    rword = acc;
          default: rword = '0;
        endcase
      end
      2'd1:    if (idx_ok) rword = a_mem[wi];
      2'd2:    if (idx_ok) rword = b_mem[wi];
      default: if (idx_ok) rword = c_mem[wi];
    endcase
  end

  assign wr       = dmem.dmem_req && (dmem.dmem_cmd == CMD_WR);
  assign ctrl_wr  = wr && (region == 2'd0) && (idx == 6'd0);
  assign new_mode = be[0] ? wd[2:1] : ctrl_mode;
  assign go_req   = ctrl_wr && be[0] && wd[0];
  assign start    = go_req && !busy && (new_mode != MODE_RSV);
  assign done_w1c = ctrl_wr && be[3] && wd[31];
  assign a_wr     = wr && !busy && idx_ok && (region == 2'd1);
  assign b_wr     = wr && !busy && idx_ok && (region == 2'd2);

  // All lanes of one step live in the same word since LANES_PER_CYC divides the lanes per word.
  logic [WW-1:0]     sw;
  int                lb;
  logic [31:0]       c_step, acc_step;
  logic [LANE_W-1:0] al, bl;
  logic [PW-1:0]     pr;

  always_comb begin
    sw       = WW'(int'(step) / SPW);
    lb       = (int'(step) % SPW) * LANES_PER_CYC;
    c_step   = c_mem[sw];
    acc_step = acc;
    al       = '0;
    bl       = '0;
    pr       = '0;
    for (int j = 0; j < LANES_PER_CYC; j++) begin
      al = a_mem[sw][(lb + j) * LANE_W +: LANE_W];
      bl = b_mem[sw][(lb + j) * LANE_W +: LANE_W];
      pr = lane_mul(al, bl);
      c_step[(lb + j) * LANE_W +: LANE_W] = lane_res(run_mode, al, bl);
      if (run_mode == MODE_MAC) acc_step = acc_step + 32'(pr);
    end
  end

  // p1: bus response/read data, buffers and run controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctrl_mode <= '0;
      ctrl_ie   <= 1'b0;
      run_mode  <= '0;
      step      <= '0;
      cycles    <= '0;
      acc       <= '0;
      resp_p1   <= RESP_NOTRDY;
      rdata_p1  <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      resp_p1 <= dmem.dmem_req ? RESP_OK : RESP_NOTRDY;
      if (dmem.dmem_req) rdata_p1 <= rword >> {off, 3'b000};
      if (ctrl_wr && be[0]) begin
        ctrl_mode <= wd[2:1];
        ctrl_ie   <= wd[3];
      end
      if (a_wr) a_mem[wi] <= (a_mem[wi] & ~bmask) | (wd & bmask);
      if (b_wr) b_mem[wi] <= (b_mem[wi] & ~bmask) | (wd & bmask);
      if (start) begin
        state    <= ST_RUN;
        run_mode <= new_mode;
        step     <= '0;
        cycles   <= '0;
        acc      <= '0;
        for (int i = 0; i < NWORDS; i++) c_mem[i] <= '0;
      end else if (busy) begin
        c_mem[sw] <= c_step;
        acc       <= acc_step;
        step      <= step + SW'(1);
        if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
        if (step == SW'(STEPS - 1)) state <= ST_DONE;
      end else if (done && done_w1c) begin
        state <= ST_IDLE;
      end
    end
  end

  assign dmem.dmem_req_ack = 1'b1;
  assign dmem.dmem_resp    = resp_p1;
  assign dmem.dmem_rdata   = rdata_p1;
  assign irq               = done & ctrl_ie;
endmodule

// File: tb/tb_scr1_simd_accel.sv
// Directed + randomized bench for scr1_simd_accel; three parameterisations share one bus driver.
module tb_scr1_simd_accel;
  localparam logic [1:0] W_BYTE = 2'b00, W_HWORD = 2'b01, W_WORD = 2'b10;
  localparam logic [1:0] R_NOTRDY = 2'b00, R_OK = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, cmd = 1'b0;
  logic [1:0]  width = W_WORD;
  logic [31:0] addr = '0, wdata = '0;
  int          sel = 0;
  logic [31:0] rd_a [3];
  logic [1:0]  rs_a [3];
  logic        ack_a [3];
  logic [2:0]  irq_v;
  int          checks = 0, failures = 0;

  int          lw_a [3] = '{8, 16, 8};
  int          nw_a [3] = '{4, 4, 1};
  int          steps_a [3] = '{16, 4, 4};
  logic [31:0] ma [3][4];
  logic [31:0] mb [3][4];
  logic [31:0] mc [4];
  logic [31:0] macc;

  always #5 clk = ~clk;

  scr1_simd_accel_if bi[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bi[g].dmem_req   = req && (sel == g);
    assign bi[g].dmem_cmd   = cmd;
    assign bi[g].dmem_width = width;
    assign bi[g].dmem_addr  = addr;
    assign bi[g].dmem_wdata = wdata;
    assign rd_a[g]  = bi[g].dmem_rdata;
    assign rs_a[g]  = bi[g].dmem_resp;
    assign ack_a[g] = bi[g].dmem_req_ack;
  end

  scr1_simd_accel #(.LANE_W(8), .LANES_PER_CYC(1), .NWORDS(4))
    u_d0 (.clk(clk), .rst_n(rst_n), .dmem(bi[0]), .irq(irq_v[0]));
  scr1_simd_accel #(.LANE_W(16), .LANES_PER_CYC(2), .NWORDS(4))
    u_d1 (.clk(clk), .rst_n(rst_n), .dmem(bi[1]), .irq(irq_v[1]));
  scr1_simd_accel #(.LANE_W(8), .LANES_PER_CYC(1), .NWORDS(1))
    u_d2 (.clk(clk), .rst_n(rst_n), .dmem(bi[2]), .irq(irq_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input int s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    sel = s; addr = a; wdata = d; width = w; cmd = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; cmd = 1'b0;
  endtask

  task automatic bus_rd(input int s, input logic [31:0] a, input logic [1:0] w, output logic [31:0] d);
    sel = s; addr = a; width = w; cmd = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    d = rd_a[s];
  endtask

  task automatic rd_chk(input int s, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus_rd(s, a, W_WORD, v);
    chk(tag, v, exp);
  endtask

  // Byte-lane write that also updates the bench's copy of the operand buffers.
  task automatic wr_ab(input int s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    logic [3:0]  be;
    logic [31:0] m, wd;
    int          i, o;
    i  = int'(a[7:2]);
    o  = int'(a[1:0]);
    be = (w == W_BYTE) ? 4'b0001 : (w == W_HWORD) ? 4'b0011 : 4'b1111;
    be = be << o;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    wd = d << (8 * o);
    if (i < nw_a[s]) begin
      if (a[9:8] == 2'd1) ma[s][i] = (ma[s][i] & ~m) | (wd & m);
      else if (a[9:8] == 2'd2) mb[s][i] = (mb[s][i] & ~m) | (wd & m);
    end
    bus_wr(s, a, d, w);
  endtask

  task automatic go(input int s, input int mode, input int ie);
    bus_wr(s, 32'h0, 32'((ie << 3) | (mode << 1) | 1), W_WORD);
  endtask

  task automatic wait_done(input int s);
    logic [31:0] v;
    int n = 0;
    do begin
      bus_rd(s, 32'h0, W_WORD, v);
      n++;
    end while (!v[31] && n < 300);
    chk("done_seen", {31'b0, v[31]}, 32'd1);
  endtask

  // Reference: every lane of every word evaluated with plain arithmetic.
  function automatic void run_model(input int s, input int mode);
    longint unsigned m, av, bv, p, r;
    int lw = lw_a[s];
    m    = (64'd1 << lw) - 1;
    macc = '0;
    for (int w = 0; w < 4; w++) begin
      mc[w] = '0;
      if (w < nw_a[s]) begin
        for (int l = 0; l < 32 / lw; l++) begin
          av = (64'(ma[s][w]) >> (l * lw)) & m;
          bv = (64'(mb[s][w]) >> (l * lw)) & m;
          p  = av * bv;
          r  = (mode == 1) ? ((av + bv) & m) : (p & m);
          mc[w] = mc[w] | 32'(r << (l * lw));
          if (mode == 2) macc = macc + 32'(p);
        end
      end
    end
  endfunction

  task automatic check_results(input int s, input string tag);
    for (int i = 0; i < nw_a[s]; i++) rd_chk(s, 32'(32'h300 + 4 * i), mc[i], $sformatf("%s_c%0d", tag, i));
    rd_chk(s, 32'h8, macc, {tag, "_acc"});
    rd_chk(s, 32'h4, 32'(steps_a[s]), {tag, "_cycles"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, a0_old;
    for (int s = 0; s < 3; s++) for (int i = 0; i < 4; i++) begin ma[s][i] = '0; mb[s][i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_resp%0d", s), {30'b0, rs_a[s]}, {30'b0, R_NOTRDY});
      chk($sformatf("rst_rdata%0d", s), rd_a[s], 32'h0);
      chk($sformatf("rst_irq%0d", s), {31'b0, irq_v[s]}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) chk($sformatf("req_ack%0d", s), {31'b0, ack_a[s]}, 32'd1);
    rd_chk(0, 32'h0, 32'h0, "ctrl_after_rst");
    bus_rd(0, 32'h8, W_WORD, v);
    chk("resp_ok", {30'b0, rs_a[0]}, {30'b0, R_OK});
    @(posedge clk); #1;
    chk("resp_idle", {30'b0, rs_a[0]}, {30'b0, R_NOTRDY});

    // 1: MUL over bytes, exact run length
    wr_ab(0, 32'h100, 32'h04030201, W_WORD);
    wr_ab(0, 32'h200, 32'h05050505, W_WORD);
    go(0, 0, 0);
    repeat (15) @(posedge clk);
    #1;
    rd_chk(0, 32'h0, 32'h40000000, "t1_busy_last");
    rd_chk(0, 32'h0, 32'h80000000, "t1_done");
    rd_chk(0, 32'h300, 32'h140F0A05, "t1_c0");
    rd_chk(0, 32'h4, 32'd16, "t1_cycles");

    // 2: ADD with lane wrap
    wr_ab(0, 32'h100, 32'hFF80017F, W_WORD);
    wr_ab(0, 32'h200, 32'h01800101, W_WORD);
    go(0, 1, 0);
    wait_done(0);
    rd_chk(0, 32'h300, 32'h00000280, "t2_c0");
    for (int i = 1; i < 4; i++) rd_chk(0, 32'(32'h300 + 4 * i), 32'h0, $sformatf("t2_c%0d", i));

    // 3: MAC with interrupt, then DONE write-one-to-clear
    for (int i = 0; i < 4; i++) begin
      wr_ab(0, 32'(32'h100 + 4 * i), 32'h01010101, W_WORD);
      wr_ab(0, 32'(32'h200 + 4 * i), 32'h02020202, W_WORD);
    end
    go(0, 2, 1);
    wait_done(0);
    rd_chk(0, 32'h8, 32'h20, "t3_acc");
    rd_chk(0, 32'h300, 32'h02020202, "t3_c0");
    chk("t3_irq_set", {31'b0, irq_v[0]}, 32'd1);
    bus_wr(0, 32'h0, 32'h8000000C, W_WORD);
    chk("t3_irq_clr", {31'b0, irq_v[0]}, 32'd0);
    rd_chk(0, 32'h0, 32'h0000000C, "t3_ctrl");

    // Reserved mode: GO does not start a run
    bus_wr(0, 32'h0, 32'h00000007, W_WORD);
    rd_chk(0, 32'h0, 32'h00000006, "rsv_go_ignored");

    // 4: GO and A write while busy are ignored
    for (int i = 0; i < 4; i++) begin
      wr_ab(0, 32'(32'h100 + 4 * i), $urandom, W_WORD);
      wr_ab(0, 32'(32'h200 + 4 * i), $urandom, W_WORD);
    end
    a0_old = ma[0][0];
    go(0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    bus_wr(0, 32'h0, 32'h00000001, W_WORD);
    bus_wr(0, 32'h100, ~a0_old, W_WORD);
    repeat (9) @(posedge clk);
    #1;
    rd_chk(0, 32'h0, 32'h40000000, "t4_busy_last");
    rd_chk(0, 32'h0, 32'h80000000, "t4_done");
    rd_chk(0, 32'h100, a0_old, "t4_a0_kept");
    run_model(0, 0);
    check_results(0, "t4");

    // 5: sub-word writes and reads
    wr_ab(0, 32'h100, 32'h11223344, W_WORD);
    wr_ab(0, 32'h102, 32'h000000AB, W_BYTE);
    rd_chk(0, 32'h100, 32'h11AB3344, "t5_byte_wr");
    bus_rd(0, 32'h101, W_BYTE, v);
    chk("t5_byte_rd", {24'b0, v[7:0]}, 32'h33);
    wr_ab(0, 32'h206, 32'h0000BEEF, W_HWORD);
    rd_chk(0, 32'h204, mb[0][1], "t5_hword_wr");
    chk("t5_hword_hi", {16'b0, mb[0][1][31:16]}, 32'h0000BEEF);

    // Unmapped and out-of-range indices
    rd_chk(2, 32'h104, 32'h0, "oob_a_rd");
    bus_wr(2, 32'h104, 32'hDEADBEEF, W_WORD);
    rd_chk(2, 32'h104, 32'h0, "oob_a_wr_dropped");
    rd_chk(0, 32'h3FC, 32'h0, "unmapped_rd");
    rd_chk(0, 32'h00C, 32'h0, "unmapped_ctrl_rd");

    // Randomized runs on all three configurations
    for (int s = 0; s < 3; s++) begin
      for (int mode = 0; mode < 3; mode++) begin
        for (int i = 0; i < nw_a[s]; i++) begin
          wr_ab(s, 32'(32'h100 + 4 * i), $urandom, W_WORD);
          wr_ab(s, 32'(32'h200 + 4 * i), $urandom, W_WORD);
        end
        go(s, mode, 0);
        wait_done(s);
        run_model(s, mode);
        check_results(s, $sformatf("rnd_s%0d_m%0d", s, mode));
      end
    end

    // 6: reset in the middle of a run
    go(0, 2, 1);
    repeat (6) @(posedge clk);
    #1;
    bus_rd(0, 32'h100, W_WORD, v);
    rst_n = 1'b0;
    #1;
    chk("t6_resp", {30'b0, rs_a[0]}, {30'b0, R_NOTRDY});
    chk("t6_rdata", rd_a[0], 32'h0);
    chk("t6_irq", {31'b0, irq_v[0]}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk(0, 32'h0, 32'h0, "t6_ctrl");
    rd_chk(0, 32'h300, 32'h0, "t6_c0");
    rd_chk(0, 32'h8, 32'h0, "t6_acc");
    rd_chk(0, 32'h100, 32'h0, "t6_a0");
    rd_chk(0, 32'h4, 32'h0, "t6_cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
